spi_aes_frame_ctrl: RTL

Slave-side frame controller sitting directly downstream of `slave_full`. On each completed 392-bit SPI frame it decodes the command header, extracts the plaintext and key, and runs one job on the AES core. It then assembles a 392-bit response word that drives `slave_full.data_in` and is shifted back to the master on the next transfer.

---
 rtl/spi_aes_frame_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/spi_aes_frame_ctrl.sv
// Slave-side SPI frame controller: decodes a 392-bit command frame, runs one AES job
// and assembles the 392-bit response word that goes back out on the next transfer.
module spi_aes_frame_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         slave_done,
    input  logic [391:0] slave_data_out,
    output logic         aes_start,
    output logic [255:0] aes_key,
    output logic [1:0]   aes_key_size,
    output logic         aes_decrypt,
    output logic [127:0] aes_block_in,
    input  logic         aes_done,
    input  logic [127:0] aes_block_out,
    output logic [391:0] resp_data,
    output logic         resp_valid,
    output logic         busy
);

    // state  | meaning
    // S_IDLE | waiting for a slave_done rising edge
    // S_START| one-cycle aes_start pulse
    // S_WAIT | waiting for aes_done, bounded by the timeout counter
    // S_RESP | resp_data just written, resp_valid high
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LOAD = CW'(TIMEOUT_CYCLES);

    state_t         state_q, state_d;
    logic           done_q;
    logic           armed_q;
    logic           done_rise;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [7:0]     seq_q, seq_d;
    logic           ovr_q, ovr_d;
    logic           ovr_now;
    logic [255:0]   key_q, key_d;
    logic [1:0]     ksz_q, ksz_d;
    logic           dec_q, dec_d;
    logic [127:0]   blk_q, blk_d;
    logic [391:0]   resp_q, resp_d;
    logic           resp_go;
    logic           st_ok, st_bad, st_to;
    logic [127:0]   result;
    logic [1:0]     hdr_ksz;
    logic           unused_hdr;

    assign hdr_ksz    = slave_data_out[385:384];
    assign unused_hdr = ^slave_data_out[391:387];

    // armed_q masks the first cycle after reset so a level already high at release is not an edge
    assign done_rise = slave_done & ~done_q & armed_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seq_d   = seq_q;
        key_d   = key_q;
        ksz_d   = ksz_q;
        dec_d   = dec_q;
        blk_d   = blk_q;
        resp_d  = resp_q;
        resp_go = 1'b0;
        st_ok   = 1'b0;
        st_bad  = 1'b0;
        st_to   = 1'b0;
        result  = '0;
        ovr_now = ovr_q | (done_rise & (state_q != S_IDLE));
        ovr_d   = ovr_now;

        case (state_q)
            S_IDLE: begin
                if (done_rise) begin
                    ksz_d = hdr_ksz;
                    dec_d = slave_data_out[386];
                    case (hdr_ksz)
                        2'b00: begin
                            key_d = {128'b0, slave_data_out[127:0]};
                            blk_d = slave_data_out[255:128];
                        end
                        2'b01: begin
                            key_d = {64'b0, slave_data_out[191:0]};
                            blk_d = slave_data_out[319:192];
                        end
                        2'b10: begin
                            key_d = slave_data_out[255:0];
                            blk_d = slave_data_out[383:256];
                        end
                        default: begin
                            key_d = '0;
                            blk_d = '0;
                        end
                    endcase
                    if (hdr_ksz == 2'b11) begin
                        resp_go = 1'b1;
                        st_bad  = 1'b1;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                cnt_d   = TO_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // aes_done takes priority over an expiring timeout in the same cycle
                if (aes_done) begin
                    resp_go = 1'b1;
                    st_ok   = 1'b1;
                    result  = aes_block_out;
                end else if (cnt_q == '0) begin
                    resp_go = 1'b1;
                    st_to   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (resp_go) begin
            state_d = S_RESP;
            resp_d  = {248'b0, seq_q, 4'b0, ovr_now, st_to, st_bad, st_ok, result};
            seq_d   = seq_q + 8'd1;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            armed_q <= 1'b0;
            cnt_q   <= '0;
            seq_q   <= '0;
            ovr_q   <= 1'b0;
            key_q   <= '0;
            ksz_q   <= '0;
            dec_q   <= 1'b0;
            blk_q   <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= slave_done;
            armed_q <= 1'b1;
            cnt_q   <= cnt_d;
            seq_q   <= seq_d;
            ovr_q   <= ovr_d;
            key_q   <= key_d;
            ksz_q   <= ksz_d;
            dec_q   <= dec_d;
            blk_q   <= blk_d;
            resp_q  <= resp_d;
        end
    end

    assign aes_start    = (state_q == S_START);
    assign resp_valid   = (state_q == S_RESP);
    assign busy         = (state_q != S_IDLE);
    assign aes_key      = key_q;
    assign aes_key_size = ksz_q;
    assign aes_decrypt  = dec_q;
    assign aes_block_in = blk_q;
    assign resp_data    = resp_q;

endmodule
